// File: rtl/column_fifo_pkg.sv
// column_fifo_pkg: shared defaults, FSM state encoding and sizing helpers for column_fifo.
// Character geometry (CHAR_H, CHAR_W, CPSBLN) normally arrives as macros from definitions.vh.
// The guarded fallbacks below only apply when no such definition is present.
// Optional feature macro used by column_fifo: KARAOKE_STALL_CNT_EN.

`ifndef CHAR_H
`define CHAR_H 8
`endif

`ifndef CHAR_W
`define CHAR_W 6
`endif

`ifndef CPSBLN
`define CPSBLN 4
`endif

package column_fifo_pkg;

    // Geometry defaults picked up by the top-level parameters.
    localparam int unsigned DefCharH  = `CHAR_H;
    localparam int unsigned DefCharW  = `CHAR_W;
    localparam int unsigned DefCpsbln = `CPSBLN;

    // Stall counter width when the optional counter is built in.
    localparam int unsigned StallCntW = 16;

    // FSM encoding: hold output back until enough columns are buffered, then stream.
    localparam logic [0:0] StPrime = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    // Index counters need at least one bit even when the modulus is 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/column_ram.sv
// column_ram: DEPTH x WIDTH storage, one synchronous write port, asynchronous read port.
// Contents are intentionally not reset; the FIFO tracks validity through its pointers.

module column_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Fall-through read: the head word is visible in the same cycle.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/column_fifo.sv
// column_fifo: buffers character columns from the bus-line ROM and tags each with
// end-of-character / end-of-line markers. Output is held back (PRIME) until a full
// character or a complete line is buffered, then streams first-word fall-through (RUN).
// Optional: define KARAOKE_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.

module column_fifo
    import column_fifo_pkg::*;
#(
    parameter int unsigned CHAR_H = DefCharH,
    parameter int unsigned CHAR_W = DefCharW,
    parameter int unsigned CPSBLN = DefCpsbln,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CHAR_H-1:0]      in_col,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CHAR_H-1:0]      out_col,
    output logic                   out_eoc,
    output logic                   out_eol,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
`ifdef KARAOKE_STALL_CNT_EN
    ,
    output logic [StallCntW-1:0]   stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = idx_width(CHAR_W);
    localparam int unsigned KW = idx_width(CPSBLN);

    localparam logic [LW-1:0] LvlFull  = LW'(DEPTH);
    localparam logic [LW-1:0] LvlPrime = LW'(CHAR_W);
    localparam logic [CW-1:0] ColLast  = CW'(CHAR_W - 1);
    localparam logic [KW-1:0] CharLast = KW'(CPSBLN - 1);

    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CW-1:0]       col_idx_q, col_idx_d;
    logic [KW-1:0]       char_idx_q, char_idx_d;
    logic [0:0]          state_q, state_d;

    logic                wr_en;
    logic                rd_en;
    logic                tag_eoc;
    logic                tag_eol;
    logic [CHAR_H+1:0]   rdata;

    // Handshake: a read frees a slot in the same cycle, so a full buffer can still accept.
    always_comb begin
        out_valid = (state_q == StRun) && (level_q != '0);
        rd_en     = out_valid && out_ready;
        in_ready  = (level_q != LvlFull) || rd_en;
        wr_en     = in_valid && in_ready;
    end

    // Tags for the column being written, derived from its position in the line.
    always_comb begin
        tag_eoc = (col_idx_q == ColLast);
        tag_eol = tag_eoc && (char_idx_q == CharLast);
    end

    // Pointer, occupancy and column/character position next-state.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        col_idx_d  = col_idx_q;
        char_idx_d = char_idx_q;

        if (wr_en) begin
            wptr_d = wptr_q + AW'(1);
            if (tag_eoc) begin
                col_idx_d  = '0;
                char_idx_d = tag_eol ? '0 : char_idx_q + KW'(1);
            end else begin
                col_idx_d = col_idx_q + CW'(1);
            end
        end

        if (rd_en) begin
            rptr_d = rptr_q + AW'(1);
        end

        level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end

    // PRIME waits for a whole character (or a short line's eol); RUN returns to PRIME
    // only when the line's last column drains the buffer, so plain underruns stay in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StPrime: begin
                if ((level_d >= LvlPrime) || (wr_en && tag_eol)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rd_en && out_eol && (level_d == '0)) begin
                    state_d = StPrime;
                end
            end
            default: state_d = StPrime;
        endcase
    end

    // State registers; reset discards everything buffered and restarts tagging.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            col_idx_q  <= '0;
            char_idx_q <= '0;
            state_q    <= StPrime;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            col_idx_q  <= col_idx_d;
            char_idx_q <= char_idx_d;
            state_q    <= state_d;
        end
    end

    column_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_H + 2)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i ({tag_eol, tag_eoc, in_col}),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    // Unpack the head word; stored as {eol, eoc, column}.
    always_comb begin
        out_col = rdata[CHAR_H-1:0];
        out_eoc = rdata[CHAR_H];
        out_eol = rdata[CHAR_H+1];
        level   = level_q;
    end

`ifdef KARAOKE_STALL_CNT_EN
    logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where upstream offers a column that cannot be taken; saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != {StallCntW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + StallCntW'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_column_fifo.sv
// tb_column_fifo: directed vector table plus hand-written corner sequences and a
// randomized scoreboard run for column_fifo (CHAR_H=8, CHAR_W=6, CPSBLN=4, DEPTH=32).

module tb_column_fifo;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_col;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_col;
    logic       out_eoc;
    logic       out_eol;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] level;
`ifdef KARAOKE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    column_fifo #(
        .CHAR_H (8),
        .CHAR_W (6),
        .CPSBLN (4),
        .DEPTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_col    (in_col),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_col   (out_col),
        .out_eoc   (out_eoc),
        .out_eol   (out_eol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
`ifdef KARAOKE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cval(input int i);
        return 8'(i * 37 + 5);
    endfunction

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] col;
        logic       ir;
        logic       ov;
        logic [5:0] lvl;
        logic       dchk;
        logic [7:0] dcol;
        logic       eoc;
        logic       eol;
    } vec_t;

    vec_t vecs [13];

    // Reset held across two edges; values checked while rst is low.
    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_col    = 8'h00;
        #1;
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [9:0] sb_q [$];
    bit         m_run;
    int         widx;
    int         nw;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_col    = 8'h00;

        //              iv ordy col    ir ov lvl   dchk dcol   eoc eol
        vecs[0]  = '{T, T, 8'hA0, T, F, 6'd0, F, 8'h00, F, F};
        vecs[1]  = '{T, T, 8'hA1, T, F, 6'd1, F, 8'h00, F, F};
        vecs[2]  = '{T, T, 8'hA2, T, F, 6'd2, F, 8'h00, F, F};
        vecs[3]  = '{T, T, 8'hA3, T, F, 6'd3, F, 8'h00, F, F};
        vecs[4]  = '{T, T, 8'hA4, T, F, 6'd4, F, 8'h00, F, F};
        vecs[5]  = '{T, T, 8'hA5, T, F, 6'd5, F, 8'h00, F, F};
        vecs[6]  = '{F, T, 8'h00, T, T, 6'd6, T, 8'hA0, F, F};
        vecs[7]  = '{F, T, 8'h00, T, T, 6'd5, T, 8'hA1, F, F};
        vecs[8]  = '{F, T, 8'h00, T, T, 6'd4, T, 8'hA2, F, F};
        vecs[9]  = '{F, T, 8'h00, T, T, 6'd3, T, 8'hA3, F, F};
        vecs[10] = '{F, T, 8'h00, T, T, 6'd2, T, 8'hA4, F, F};
        vecs[11] = '{F, T, 8'h00, T, T, 6'd1, T, 8'hA5, T, F};
        vecs[12] = '{F, T, 8'h00, T, F, 6'd0, F, 8'h00, F, F};

        @(negedge clk);
        do_reset();

        // Priming on the sixth column, then fall-through drain and tolerated underrun.
        for (int i = 0; i < 13; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_col    = vecs[i].col;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].ir);
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
            chk($sformatf("vec%0d level", i), level, vecs[i].lvl);
            if (vecs[i].dchk) begin
                chk($sformatf("vec%0d out_col", i), out_col, vecs[i].dcol);
                chk($sformatf("vec%0d out_eoc", i), out_eoc, vecs[i].eoc);
                chk($sformatf("vec%0d out_eol", i), out_eol, vecs[i].eol);
            end
            @(negedge clk);
        end

        // One full line, then drain: eol exit back to PRIME.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            in_valid = 1'b1;
            in_col   = cval(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("line_level", level, 24);
        chk("line_out_valid", out_valid, 1);
        for (int k = 0; k < 24; k++) begin
            out_ready = 1'b1;
            #1;
            chk($sformatf("line_rd%0d valid", k), out_valid, 1);
            chk($sformatf("line_rd%0d col", k), out_col, cval(k));
            chk($sformatf("line_rd%0d eoc", k), out_eoc, (k % 6) == 5);
            chk($sformatf("line_rd%0d eol", k), out_eol, k == 23);
            @(negedge clk);
        end
        #1;
        chk("line_drained_level", level, 0);
        chk("line_drained_valid", out_valid, 0);
        in_valid = 1'b1;
        in_col   = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("line_prime_level", level, 1);
        chk("line_prime_valid", out_valid, 0);

        // Overfill with the consumer stalled.
        do_reset();
        nw = 0;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_col   = cval(k);
            #1;
            if (in_ready) nw++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("full_writes", nw, 32);
        chk("full_level", level, 32);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
`ifdef KARAOKE_STALL_CNT_EN
        chk("full_stall_cnt", stall_cnt, 8);
`endif

        // Simultaneous read and write at full.
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_col    = cval(32 + k);
            #1;
            chk($sformatf("rw%0d in_ready", k), in_ready, 1);
            chk($sformatf("rw%0d out_valid", k), out_valid, 1);
            chk($sformatf("rw%0d level", k), level, 32);
            chk($sformatf("rw%0d col", k), out_col, cval(k));
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("rw_level_after", level, 32);
        for (int k = 10; k < 42; k++) begin
            out_ready = 1'b1;
            #1;
            chk($sformatf("rwd%0d col", k), out_col, cval(k));
            chk($sformatf("rwd%0d eoc", k), out_eoc, (k % 6) == 5);
            chk($sformatf("rwd%0d eol", k), out_eol, (k % 24) == 23);
            @(negedge clk);
        end
        #1;
        chk("rw_drained_level", level, 0);

        // Reset mid-character, then retagging from column 0.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            in_col   = cval(100 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("mid_level", level, 17);
        rst = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_col   = cval(200 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("retag_level", level, 6);
        chk("retag_valid", out_valid, 1);
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b1;
            #1;
            chk($sformatf("retag%0d col", k), out_col, cval(200 + k));
            chk($sformatf("retag%0d eoc", k), out_eoc, k == 5);
            chk($sformatf("retag%0d eol", k), out_eol, 0);
            @(negedge clk);
        end

        // Randomized traffic against a scoreboard and reference state model.
        do_reset();
        sb_q.delete();
        m_run = 1'b0;
        widx  = 0;
        for (int c = 0; c < 5000; c++) begin
            int   blk;
            int   m_lvl;
            bit   m_ov;
            bit   m_rd;
            bit   m_ir;
            bit   wr;
            bit   w_eoc;
            bit   w_eol;
            bit   head_eol;
            blk       = (c / 500) % 3;
            in_valid  = ($urandom_range(0, 99) < ((blk == 0) ? 85 : 50));
            out_ready = ($urandom_range(0, 99) < ((blk == 1) ? 85 : ((blk == 0) ? 30 : 55)));
            in_col    = 8'($urandom_range(0, 255));
            #1;
            m_lvl = sb_q.size();
            m_ov  = m_run && (m_lvl != 0);
            m_rd  = m_ov && out_ready;
            m_ir  = (m_lvl < 32) || m_rd;
            chk($sformatf("rnd%0d level", c), level, m_lvl);
            chk($sformatf("rnd%0d out_valid", c), out_valid, m_ov);
            chk($sformatf("rnd%0d in_ready", c), in_ready, m_ir);
            head_eol = 1'b0;
            if (m_ov) begin
                chk($sformatf("rnd%0d head", c), {out_eol, out_eoc, out_col}, sb_q[0]);
                head_eol = sb_q[0][9];
            end
            if (m_rd) void'(sb_q.pop_front());
            wr    = in_valid && m_ir;
            w_eoc = (widx % 6) == 5;
            w_eol = (widx % 24) == 23;
            if (wr) begin
                sb_q.push_back({w_eol, w_eoc, in_col});
                widx++;
            end
            if (!m_run) begin
                if ((sb_q.size() >= 6) || (wr && w_eol)) m_run = 1'b1;
            end else if (m_rd && head_eol && (sb_q.size() == 0)) begin
                m_run = 1'b0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
